act_skew_feeder: RTL and testbench
==================================

// Module: act_skew_feeder
// PURPOSE
//  Activation front-end for the systolic array. Accepts one N-element activation vector per cycle
//  from the SRAM read port via valid/ready. Drives element i into the left_in of array row i,
//  delayed by i extra cycles, to form the diagonal wavefront the PE grid needs.
//  Sequences one job of num_vec vectors (IDLE->FEED->DRAIN) and pulses done when the last element exits.
// PARAMETERS
//  N      4   array rows = vector elements
//  D_W    8   activation width, matches PE D_W
//  LEN_W  8   width of vector-count field
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        reset, asynchronous, active-high
//  start      in   1        job start pulse; sampled only in IDLE
//  num_vec    in   LEN_W    vectors in job; sampled with start
//  in_valid   in   1        in_data holds a vector
//  in_ready   out  1        feeder accepts in_data this cycle
//  in_data    in   N*D_W    element i at [i*D_W +: D_W]
//  row_out    out  N*D_W    to row i left_in, slice [i*D_W +: D_W]
//  row_valid  out  N        row_out slice i carries real data
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle job-complete pulse
// BEHAVIOUR
//  Reset (async): state=IDLE, counters=0, all skew registers=0. row_out=0, row_valid=0,
//   in_ready=0, busy=0, done=0. Reset mid-job aborts at once and drops in-flight data; no done.
//  Skew: row i has a chain of i+1 registers (data+valid) that shifts every cycle, never stalls.
//   The chain head loads in_data[i]/1 on an accept (in_valid&in_ready), else 0/0.
//   Vector accepted at edge e shows on row i after edge e+i (row 0 latency 1, row N-1 latency N).
//  Bubbles: a FEED cycle without accept injects data=0,valid=0. Zero data adds nothing to psum.
//  IDLE: in_ready=0. On start & num_vec!=0: latch num_vec, clear vec_cnt, go to FEED.
//   On start & num_vec==0: stay IDLE, done=1 next cycle. start outside IDLE is ignored.
//  FEED: in_ready=1. Each accept increments vec_cnt.
//   The accept that makes vec_cnt==num_vec goes to DRAIN, with drain_cnt=0.
//  DRAIN: in_ready=0. drain_cnt increments each cycle.
//   When drain_cnt==N-2, go to IDLE and assert done for the next cycle.
//   That cycle is the one in which row N-1 shows the last element.
//   For N==1, DRAIN is skipped: FEED goes straight to IDLE with done.
//  done is registered, high exactly 1 cycle per job. busy deasserts in that same cycle.
//  Simultaneous start & done cycle: start is honoured, since state is already IDLE.
//  vec_cnt is LEN_W bits and never wraps: max job is 2^LEN_W-1 vectors.
// TESTING
//  T1 reset: rst pulse mid-FEED with data in chains -> next cycle all outputs 0, busy=0, no done.
//  T2 skew, N=4, num_vec=1, in_data={8'h44,8'h33,8'h22,8'h11}, accept at edge 0 ->
//     row0=11 after edge0, row1=22 after edge1, row2=33 after edge2, row3=44 after edge3;
//     done=1 with row3 valid; row_valid matches each.
//  T3 back-to-back num_vec=3, in_valid held 1 -> in_ready high 3 cycles.
//     Each row shows 3 consecutive valid values. done 3 cycles after the last accept (N=4).
//  T4 bubble: num_vec=2, in_valid low 2 cycles between vectors -> each row shows v0,0,0,v1
//     with row_valid 1,0,0,1. vec_cnt holds during the gap.
//  T5 edge cases: start with num_vec=0 -> done pulse next cycle, no row_valid.
//     start during FEED -> ignored, job count unchanged.
//  T6 back-to-back jobs: start asserted in done cycle -> new job begins; row_valid gap <= 1 cycle.

Source files
------------

// File: rtl/act_skew_feeder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : act_skew_feeder_if
// Description : Activation vector stream from the SRAM read port (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface act_skew_feeder_if #(
    parameter int N   = 4,
    parameter int D_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [N*D_W-1:0]   in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/act_skew_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : act_skew_feeder
// Description : Skews activation vectors into a diagonal wavefront for the
//               systolic array rows and sequences one job (IDLE/FEED/DRAIN).
// Revision    : 1.0 - initial release
// ============================================================================
module act_skew_feeder #(
    parameter int N     = 4,
    parameter int D_W   = 8,
    parameter int LEN_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start_i,
    input  wire logic [LEN_W-1:0]   num_vec_i,
    act_skew_feeder_if.slave        in_if,
    output logic [N*D_W-1:0]        row_out_o,
    output logic [N-1:0]            row_valid_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int C_CNT_W = (N > 2) ? $clog2(N - 1) : 1;
    // Last drain count: the cycle after it, row N-1 presents the final element.
    localparam logic [C_CNT_W-1:0] C_DRAIN_LAST = C_CNT_W'((N > 1) ? (N - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    num_q, num_d;
    logic [LEN_W-1:0]    vec_q, vec_d;
    logic [C_CNT_W-1:0]  drain_q, drain_d;
    logic                done_q, done_d;
    logic                w_accept;
    logic [LEN_W-1:0]    w_vec_inc;

    assign w_accept    = in_if.in_valid && (state_q == S_FEED);
    assign w_vec_inc   = vec_q + 1'b1;
    assign in_if.in_ready = (state_q == S_FEED);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            vec_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_vec_i != '0) begin
                        num_d   = num_vec_i;
                        vec_d   = '0;
                        state_d = S_FEED;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (w_accept) begin
                    vec_d = w_vec_inc;
                    if (w_vec_inc == num_q) begin
                        if (N == 1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == C_DRAIN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Row r owns r+1 free-running stages; non-accept cycles inject zero bubbles.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [D_W-1:0] skew_dat_q [0:r];
        logic [r:0]     skew_vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= r; s++) begin
                    skew_dat_q[s] <= '0;
                end
                skew_vld_q <= '0;
            end else begin
                skew_dat_q[0] <= w_accept ? in_if.in_data[r*D_W +: D_W] : '0;
                skew_vld_q[0] <= w_accept;
                for (int s = 1; s <= r; s++) begin
                    skew_dat_q[s] <= skew_dat_q[s-1];
                    skew_vld_q[s] <= skew_vld_q[s-1];
                end
            end
        end

        assign row_out_o[r*D_W +: D_W] = skew_dat_q[r];
        assign row_valid_o[r]          = skew_vld_q[r];
    end
endmodule
`default_nettype wire

// File: tb/tb_act_skew_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_act_skew_feeder
// Description : Scoreboard bench for act_skew_feeder (row skew, jobs, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_skew_feeder;
    localparam int N     = 4;
    localparam int D_W   = 8;
    localparam int LEN_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [LEN_W-1:0]   num_vec = '0;
    logic [N*D_W-1:0]   row_out;
    logic [N-1:0]       row_valid;
    logic               busy;
    logic               done;

    act_skew_feeder_if #(.N(N), .D_W(D_W)) bus ();

    act_skew_feeder #(.N(N), .D_W(D_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .num_vec_i   (num_vec),
        .in_if       (bus),
        .row_out_o   (row_out),
        .row_valid_o (row_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [D_W-1:0] d;
        int             c;
    } exp_t;

    exp_t rq [N][$];
    int   dq [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*D_W-1:0] vec(input logic [7:0] base, input int k);
        logic [N*D_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*D_W +: D_W] = D_W'(int'(base) * (i + 1) + k);
        return v;
    endfunction

    // Output monitor: pops expected row elements and done pulses by cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int r = 0; r < N; r++) begin
                if (row_valid[r]) begin
                    if (rq[r].size() == 0) begin
                        chk($sformatf("row%0d_unexpected_valid", r), 1, 0);
                    end else begin
                        e = rq[r].pop_front();
                        chk($sformatf("row%0d_data", r), row_out[r*D_W +: D_W], e.d);
                        chk($sformatf("row%0d_cycle", r), cyc, e.c);
                    end
                end else begin
                    chk($sformatf("row%0d_bubble_zero", r), row_out[r*D_W +: D_W], 0);
                    if (rq[r].size() != 0 && rq[r][0].c <= cyc) begin
                        chk($sformatf("row%0d_missing_valid", r), 0, 1);
                        void'(rq[r].pop_front());
                    end
                end
            end
            if (done) begin
                if (dq.size() != 0 && dq[0] == cyc) begin
                    chk("done_cycle", cyc, dq.pop_front());
                end else begin
                    chk("done_unexpected", 1, 0);
                end
            end else if (dq.size() != 0 && dq[0] <= cyc) begin
                chk("done_missing", 0, 1);
                void'(dq.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle so the
    // next call asserts start in that same cycle.
    task automatic run_job(input int num, input int gap, input logic [7:0] base, input bit poke,
                           output int rdy_cnt, output int busy_cnt, output bit first_busy);
        int sent, gapc, budget;
        bit first, poked;
        exp_t e;
        sent = 0; gapc = 0; budget = 0; first = 1'b1; poked = 1'b0;
        rdy_cnt = 0; busy_cnt = 0; first_busy = 1'b0;
        start   = 1'b1;
        num_vec = LEN_W'(num);
        if (num == 0) dq.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (first) begin
                first_busy = busy;
                first = 1'b0;
            end
            if (!busy && sent == num) break;
            if (budget++ > 200) begin
                chk("job_timeout", 0, 1);
                break;
            end
            if (bus.in_ready) rdy_cnt++;
            if (busy) busy_cnt++;
            start = 1'b0;
            if (poke && !poked && sent == 1) begin
                start   = 1'b1;
                num_vec = 8'd9;
                poked   = 1'b1;
            end
            bus.in_valid = (sent < num) && (gapc == 0);
            bus.in_data  = vec(base, sent);
            if (bus.in_valid && bus.in_ready) begin
                for (int r = 0; r < N; r++) begin
                    e.d = bus.in_data[r*D_W +: D_W];
                    e.c = cyc + 1 + r;
                    rq[r].push_back(e);
                end
                sent++;
                gapc = gap;
                if (sent == num) dq.push_back(cyc + N);
            end else if (gapc > 0) begin
                gapc--;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    typedef struct {
        int         num;
        int         gap;
        logic [7:0] base;
        bit         poke;
        int         exp_rdy;
        int         exp_busy;
        bit         exp_first_busy;
    } job_t;

    initial begin
        job_t jobs [7];
        int   rdy, bsy;
        bit   fb;

        jobs[0] = '{1, 0, 8'h11, 1'b0, 1, 4, 1'b1};   // 11,22,33,44 diagonal
        jobs[1] = '{3, 0, 8'h20, 1'b0, 3, 6, 1'b1};
        jobs[2] = '{2, 2, 8'h05, 1'b0, 4, 7, 1'b1};   // two bubbles between vectors
        jobs[3] = '{0, 0, 8'h00, 1'b0, 0, 0, 1'b0};   // empty job
        jobs[4] = '{3, 1, 8'h31, 1'b1, 5, 8, 1'b1};   // stray start mid-FEED
        jobs[5] = '{4, 0, 8'h07, 1'b0, 4, 7, 1'b1};
        jobs[6] = '{1, 3, 8'h09, 1'b0, 1, 4, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_row_out", row_out, 0);
        chk("reset_row_valid", row_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int j = 0; j < 7; j++) begin
            run_job(jobs[j].num, jobs[j].gap, jobs[j].base, jobs[j].poke, rdy, bsy, fb);
            chk($sformatf("job%0d_ready_cycles", j), rdy, jobs[j].exp_rdy);
            chk($sformatf("job%0d_busy_cycles", j), bsy, jobs[j].exp_busy);
            chk($sformatf("job%0d_first_busy", j), fb, jobs[j].exp_first_busy);
        end
        repeat (6) @(negedge clk);

        // Reset abort with data in flight.
        mon_en = 1'b0;
        start = 1'b1; num_vec = 8'd5;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = vec(8'h50, 0);
        @(negedge clk);
        bus.in_data = vec(8'h50, 1);
        @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_row0_valid", row_valid[0], 1);
        rst = 1'b1;
        #1;
        chk("abort_row_out", row_out, 0);
        chk("abort_row_valid", row_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("abort_next_row_valid", row_valid, 0);
        chk("abort_next_done", done, 0);
        chk("abort_next_busy", busy, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_abort_done", done, 0);
            chk("post_abort_row_valid", row_valid, 0);
        end
        for (int r = 0; r < N; r++) rq[r].delete();
        dq.delete();
        mon_en = 1'b1;

        run_job(2, 0, 8'h61, 1'b0, rdy, bsy, fb);
        chk("recover_ready_cycles", rdy, 2);
        chk("recover_busy_cycles", bsy, 5);
        repeat (6) @(negedge clk);

        for (int r = 0; r < N; r++) chk($sformatf("row%0d_queue_drained", r), rq[r].size(), 0);
        chk("done_queue_drained", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
